// File: rtl/spi_fpu_pkg.sv
// Shared types and constants for the SPI-to-FPU command sequencer.
// Opcodes, FSM states, status-byte bit positions, flag indices, qNaN.
package spi_fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  localparam int ST_VALID = 7;
  localparam int ST_ILL   = 6;
  localparam int ST_TO    = 5;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic op_legal(
    input logic [7:0] b
  );
    return (b[7:3] == 5'd0) &&
           (b[2:0] <= OP_SQRT);
  endfunction

endpackage

// File: rtl/spi_fpu_tx_mux.sv
// Selects the byte offered to the SPI shifter.
// Ports: state, idx, status, result in; tx_data out (0 outside RESP).
module spi_fpu_tx_mux
  import spi_fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IW    = 3
) (
  input  state_e             state,
  input  logic [IW-1:0]      idx,
  input  logic [7:0]         status,
  input  logic [WIDTH-1:0]   result,
  output logic [7:0]         tx_data
);

  localparam int NB = WIDTH / 8;

  always_comb begin
    tx_data = 8'h00;
    if (state == S_RESP) begin
      if (idx == '0) begin
        tx_data = status;
      end else begin
        for (int i = 1; i <= NB; i++) begin
          if (idx == IW'(i))
            tx_data = result[WIDTH-8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/spi_fpu_sequencer.sv
// Parses SPI command bytes, issues one FPU op, returns status+result.
// Ports: SPI rx/tx strobes, cs_active, FPU start/done handshake, busy.
module spi_fpu_sequencer
  import spi_fpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_active,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             tx_load,
  output logic [7:0]       tx_data,
  output logic [2:0]       fpu_op,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic             fpu_start,
  input  logic             fpu_done,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic [4:0]       fpu_flags,
  output logic             busy
);

  localparam int NB = WIDTH / 8;
  localparam int IW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT);

  state_e           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [2:0]       op, op_n;
  logic [WIDTH-1:0] a, a_n;
  logic [WIDTH-1:0] b, b_n;
  logic [WIDTH-1:0] res, res_n;
  logic [4:0]       flg, flg_n;
  logic             ill, ill_n;
  logic             to, to_n;
  logic [7:0]       status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      tcnt  <= '0;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      flg   <= '0;
      ill   <= 1'b0;
      to    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      tcnt  <= tcnt_n;
      op    <= op_n;
      a     <= a_n;
      b     <= b_n;
      res   <= res_n;
      flg   <= flg_n;
      ill   <= ill_n;
      to    <= to_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    tcnt_n    = tcnt;
    op_n      = op;
    a_n       = a;
    b_n       = b;
    res_n     = res;
    flg_n     = flg;
    ill_n     = ill;
    to_n      = to;
    fpu_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cs_active && rx_valid) begin
          op_n  = rx_data[2:0];
          a_n   = '0;
          b_n   = '0;
          flg_n = '0;
          to_n  = 1'b0;
          idx_n = '0;
          if (op_legal(rx_data)) begin
            ill_n   = 1'b0;
            state_n = S_GET_A;
          end else begin
            ill_n   = 1'b1;
            res_n   = '0;
            state_n = S_RESP;
          end
        end
      end
      S_GET_A: begin
        if (!cs_active) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (rx_valid) begin
          a_n = WIDTH'({a, rx_data});
          if (idx == IW'(NB - 1)) begin
            idx_n   = '0;
            state_n = (op == OP_SQRT) ?
                      S_ISSUE : S_GET_B;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_GET_B: begin
        if (!cs_active) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (rx_valid) begin
          b_n = WIDTH'({b, rx_data});
          if (idx == IW'(NB - 1)) begin
            idx_n   = '0;
            state_n = S_ISSUE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        fpu_start = 1'b1;
        tcnt_n    = '0;
        state_n   = cs_active ? S_WAIT : S_DRAIN;
      end
      S_WAIT: begin
        // A done or timeout coinciding with cs drop
        // ends the op outright instead of draining.
        if (fpu_done) begin
          state_n = S_IDLE;
          if (cs_active) begin
            res_n   = fpu_result;
            flg_n   = fpu_flags;
            to_n    = 1'b0;
            idx_n   = '0;
            state_n = S_RESP;
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_n = S_IDLE;
          if (cs_active) begin
            res_n   = WIDTH'(QNAN);
            flg_n   = '0;
            to_n    = 1'b1;
            idx_n   = '0;
            state_n = S_RESP;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (!cs_active)
            state_n = S_DRAIN;
        end
      end
      S_RESP: begin
        if (!cs_active) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (tx_load) begin
          if (idx == IW'(NB)) begin
            state_n = S_IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (fpu_done ||
            tcnt == TW'(TIMEOUT - 1))
          state_n = S_IDLE;
        else
          tcnt_n = tcnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    status              = '0;
    status[ST_VALID]    = 1'b1;
    status[ST_ILL]      = ill;
    status[ST_TO]       = to;
    status[FL_NV:FL_NX] = flg;
  end

  spi_fpu_tx_mux #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_tx_mux (
    .state   (state),
    .idx     (idx),
    .status  (status),
    .result  (res),
    .tx_data (tx_data)
  );

  assign fpu_op = op;
  assign fpu_a  = a;
  assign fpu_b  = b;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_spi_fpu_sequencer.sv
// Self-checking bench for spi_fpu_sequencer.
// Directed plan scenarios plus randomized commands vs a frame model.
module tb_spi_fpu_sequencer;

  localparam int W  = 32;
  localparam int NB = W / 8;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs_active = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         tx_load = 1'b0;
  logic [7:0]   tx_data;
  logic [2:0]   fpu_op;
  logic [W-1:0] fpu_a, fpu_b;
  logic         fpu_start;
  logic         fpu_done = 1'b0;
  logic [W-1:0] fpu_result = '0;
  logic [4:0]   fpu_flags = '0;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  spi_fpu_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cs_active(cs_active),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_start(fpu_start), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fpu_start) starts++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send(input logic [7:0] v, input int gmax);
    repeat ($urandom_range(0, gmax)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = v;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // dly < 0: FPU never answers. stray: spurious done in ISSUE.
  task automatic do_cmd(
    input logic [7:0] opc, input logic [W-1:0] a,
    input logic [W-1:0] b, input int dly,
    input logic [W-1:0] r, input logic [4:0] f,
    input bit stray, input int gmax, input string nm);
    bit legal, tmo;
    logic [7:0] st, e;
    logic [W-1:0] er, sh;
    int n0, cnt;
    legal = (opc < 8'd5);
    tmo = legal && (dly < 0);
    n0 = starts;
    send(opc, gmax);
    if (legal) begin
      for (int i = 0; i < NB; i++)
        send(a[W-1-8*i -: 8], gmax);
      if (opc != 8'd4)
        for (int i = 0; i < NB; i++)
          send(b[W-1-8*i -: 8], gmax);
      checks++; if (fpu_start !== 1'b1) begin errors++; $display("FAIL %s start_lat got %b exp 1", nm, fpu_start); end
      checks++; if (fpu_op !== opc[2:0]) begin errors++; $display("FAIL %s op got %h exp %h", nm, fpu_op, opc[2:0]); end
      checks++; if (fpu_a !== a) begin errors++; $display("FAIL %s a got %h exp %h", nm, fpu_a, a); end
      if (opc != 8'd4) begin
        checks++; if (fpu_b !== b) begin errors++; $display("FAIL %s b got %h exp %h", nm, fpu_b, b); end
      end
      if (stray) begin
        fpu_done = 1'b1;
        fpu_result = $urandom;
      end
      @(negedge clk);
      fpu_done = 1'b0;
      checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL %s start_width got %b exp 0", nm, fpu_start); end
      cnt = 1;
      if (tmo) begin
        while (tx_data == 8'h00 && cnt <= TO + 4) begin
          rx_valid = 1'($urandom);
          rx_data = 8'($urandom);
          @(negedge clk);
          cnt++;
        end
        rx_valid = 1'b0;
        checks++; if (cnt != TO + 1) begin errors++; $display("FAIL %s timeout_cycles got %0d exp %0d", nm, cnt, TO + 1); end
      end else begin
        while (cnt < dly) begin
          rx_valid = 1'($urandom);
          rx_data = 8'($urandom);
          @(negedge clk);
          cnt++;
        end
        rx_valid = 1'b0;
        checks++; if (fpu_a !== a) begin errors++; $display("FAIL %s a_hold got %h exp %h", nm, fpu_a, a); end
        fpu_done = 1'b1;
        fpu_result = r;
        fpu_flags = f;
        @(negedge clk);
        fpu_done = 1'b0;
        fpu_flags = 5'($urandom);
      end
    end
    checks++; if (starts - n0 != int'(legal)) begin errors++; $display("FAIL %s starts got %0d exp %0d", nm, starts - n0, int'(legal)); end
    st = {1'b1, !legal, tmo, (legal && !tmo) ? f : 5'd0};
    er = !legal ? '0 : (tmo ? 32'h7FC0_0000 : r);
    for (int k = 0; k <= NB; k++) begin
      sh = er >> (8 * (NB - k));
      e = (k == 0) ? st : sh[7:0];
      checks++; if (tx_data !== e) begin errors++; $display("FAIL %s tx[%0d] got %h exp %h", nm, k, tx_data, e); end
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat ($urandom_range(0, gmax)) @(negedge clk);
    end
    checks++; if (busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL %s end_idle got busy=%b tx=%h exp 0/00", nm, busy, tx_data); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset tx got %h exp 00", tx_data); end
    checks++; if (fpu_start !== 1'b0) begin errors++; $display("FAIL reset start got %b exp 0", fpu_start); end
    checks++; if ({fpu_op, fpu_a, fpu_b} !== '0) begin errors++; $display("FAIL reset fpu_regs got %h/%h/%h exp 0", fpu_op, fpu_a, fpu_b); end
    rst_n = 1'b1;
    @(negedge clk);
    cs_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    do_cmd(8'h00, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 5'd0, 0, 0, "add");
  endtask

  task automatic test_mul_inexact;
    do_cmd(8'h02, 32'h4000_0000, 32'h4040_0000, 1, 32'h40C0_0000, 5'b00001, 0, 0, "mul");
  endtask

  task automatic test_illegal;
    do_cmd(8'h0D, '0, '0, 0, '0, '0, 0, 0, "ill_0d");
    do_cmd(8'h05, '0, '0, 0, '0, '0, 0, 0, "ill_05");
    do_cmd(8'h07, '0, '0, 0, '0, '0, 0, 0, "ill_07");
  endtask

  task automatic test_timeout;
    do_cmd(8'h03, 32'h3F80_0000, '0, -1, '0, '0, 1, 0, "timeout");
  endtask

  task automatic test_abort;
    int n0;
    n0 = starts;
    send(8'h00, 0);
    for (int i = 0; i < 3; i++) send(8'h11, 0);
    cs_active = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b exp 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (starts != n0) begin errors++; $display("FAIL abort starts got %0d exp %0d", starts - n0, 0); end
    send(8'h00, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cs_low_rx busy got %b exp 0", busy); end
    cs_active = 1'b1;
    @(negedge clk);
    do_cmd(8'h04, 32'h4080_0000, '0, 4, 32'h4000_0000, 5'd0, 0, 0, "sqrt");
  endtask

  task automatic test_resp_abort;
    send(8'hF8, 0);
    checks++; if (tx_data !== 8'hC0) begin errors++; $display("FAIL resp_abort status got %h exp C0", tx_data); end
    cs_active = 1'b0;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    checks++; if (busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL resp_abort idle got busy=%b tx=%h exp 0/00", busy, tx_data); end
    cs_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_drain;
    int n0;
    n0 = starts;
    send(8'h01, 0);
    for (int i = 0; i < 2 * NB; i++) send(8'($urandom), 0);
    @(negedge clk);
    @(negedge clk);
    cs_active = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL drain hold[%0d] got busy=%b tx=%h exp 1/00", i, busy, tx_data); end
    end
    fpu_done = 1'b1;
    @(negedge clk);
    fpu_done = 1'b0;
    checks++; if (busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL drain end got busy=%b tx=%h exp 0/00", busy, tx_data); end
    checks++; if (starts - n0 != 1) begin errors++; $display("FAIL drain starts got %0d exp 1", starts - n0); end
    cs_active = 1'b1;
    @(negedge clk);
    do_cmd(8'h00, 32'($urandom), 32'($urandom), 2, 32'($urandom), 5'($urandom), 0, 0, "after_drain");
  endtask

  task automatic test_reset_mid;
    send(8'h02, 0);
    for (int i = 0; i < 2 * NB; i++) send(8'($urandom), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || fpu_a !== '0) begin errors++; $display("FAIL rst_mid got busy=%b a=%h exp 0/0", busy, fpu_a); end
    @(negedge clk);
    rst_n = 1'b1;
    fpu_done = 1'b1;
    @(negedge clk);
    fpu_done = 1'b0;
    checks++; if (busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_done got busy=%b tx=%h exp 0/00", busy, tx_data); end
    do_cmd(8'h01, 32'($urandom), 32'($urandom), 5, 32'($urandom), 5'($urandom), 0, 0, "after_rst");
  endtask

  task automatic test_back_to_back;
    logic [7:0] opc;
    int dly;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 8'($urandom_range(5, 255));
      else opc = 8'($urandom_range(0, 4));
      dly = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, 20);
      do_cmd(opc, 32'($urandom), 32'($urandom), dly, 32'($urandom),
             5'($urandom), 1'($urandom), 2, "rand");
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul_inexact;
    test_illegal;
    test_timeout;
    test_abort;
    test_resp_abort;
    test_drain;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_fpu_sequencer.md
Name: spi_fpu_sequencer

Overview:
- Command sequencer between the SPI byte shifter and the FPU core inside spi_fpu.
- Parses the received byte stream into an opcode plus two operands, issues one FPU operation with a start/done handshake, and enforces a timeout.
- Serves a status byte and the result bytes back to the shifter for transmission.
- Handles chip-select abort mid-frame.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8; NB = WIDTH/8 bytes.
- TIMEOUT, 64, max cycles in WAIT before forcing a timeout result; must be ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cs_active  in  1  synchronized chip-select, high while frame open
- rx_valid  in  1  one-cycle strobe, rx_data holds a complete received byte
- rx_data  in  8  received byte
- tx_load  in  1  one-cycle strobe, shifter captured tx_data; advance to next byte
- tx_data  out  8  next byte to transmit
- fpu_op  out  3  operation select
- fpu_a  out  WIDTH  operand A
- fpu_b  out  WIDTH  operand B
- fpu_start  out  1  one-cycle issue pulse
- fpu_done  in  1  one-cycle completion strobe from FPU
- fpu_result  in  WIDTH  result, valid with fpu_done
- fpu_flags  in  5  IEEE flags {NV,DZ,OF,UF,NX}, valid with fpu_done
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: clk with async active-low rst_n.
- Reset values: state=IDLE; all outputs 0; operand/result/index registers 0.
- Opcodes (rx_data[2:0], upper bits must be 0):
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SQRT (B ignored).
  - 5–7 or nonzero [7:3] are illegal.
- Operands are received MSB-first.
- States:
  - IDLE: cs_active && rx_valid → latch opcode. Legal → GET_A (idx=0). Illegal → RESP with ill=1, result=0.
  - GET_A: each rx_valid shifts the byte into A. After NB bytes → GET_B (SQRT: → ISSUE).
  - GET_B: NB bytes into B → ISSUE.
  - ISSUE: fpu_start=1 for exactly one cycle → WAIT, timeout counter=0.
  - WAIT:
    - fpu_done → latch result/flags → RESP.
    - Counter reaches TIMEOUT-1 without done → RESP with to=1, result=0x7FC00000 (qNaN), flags=0.
    - fpu_done is sampled only from the cycle after fpu_start.
  - RESP:
    - tx_data = byte[idx]; byte 0 = status {1'b1, ill, to, flags[4:0]}; bytes 1..NB = result MSB-first.
    - Each tx_load increments idx; after byte NB is loaded → IDLE.
  - DRAIN: entered on cs drop during ISSUE/WAIT. Stays until fpu_done or timeout (result discarded) → IDLE.
- tx_data is 0x00 in all states except RESP.
- fpu_op/fpu_a/fpu_b are held stable from ISSUE until leaving WAIT/DRAIN.
- Bytes that arrive in ISSUE/WAIT/RESP/DRAIN are ignored.
- cs_active low:
  - in GET_A/GET_B/RESP → IDLE next cycle, partial data discarded.
  - in ISSUE/WAIT → DRAIN.
  - cs drop wins over a simultaneous rx_valid or tx_load.
- Back-to-back commands within one open frame are allowed: after RESP the next rx_valid in IDLE is a new opcode.
- Latency: last operand byte → fpu_start = 1 cycle; fpu_done → tx_data valid status = 1 cycle.
- Async reset mid-operation returns to IDLE; any in-flight FPU result is ignored.

Decomposition:
- Package spi_fpu_pkg:
  - opcode enum (OP_ADD..OP_SQRT)
  - state enum
  - status bit positions (ST_VALID=7, ST_ILL=6, ST_TO=5)
  - QNAN constant
  - flag index constants
- Sub-module spi_fpu_tx_mux: combinational selection of tx_data from state, idx, status and result.

Test Plan:
- ADD: frame 00, 3F800000, 40000000, FPU returns 40400000 with flags=0 → fpu_start 1 cycle after last byte; tx sequence 80,40,40,00,00.
- MUL with inexact: opcode 02, A=40000000, B=40400000, result 40C00000, flags=00001 → status 81 then 40,C0,00,00.
- Illegal opcode 0x0D → no fpu_start; tx 0xC0 then 00,00,00,00; returns to IDLE.
- Timeout: fpu_done never asserted → after TIMEOUT cycles in WAIT, tx 0xA0, 7F,C0,00,00.
- Abort: cs_active low after 3 bytes of A → IDLE next cycle, no fpu_start. A following frame 04, 40800000 → SQRT issued with A=40800000.
- Drain: cs_active low during WAIT, fpu_done 5 cycles later → busy stays high until done, then IDLE; tx_data stays 00.
